// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op codes, FSM states and default width
// for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

  localparam int P_WIDTH_DEF = 32;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: execute-stage control/data bundle for muldiv_ctrl.
// o_con_DivZero exists only with MULDIV_DIVZERO_FLAG_EN.
interface muldiv_if #(
  parameter int W = 32
);
  logic         i_con_Start;
  logic [1:0]   i_con_Op;
  logic [W-1:0] i_data_A;
  logic [W-1:0] i_data_B;
  logic         i_con_MtHi;
  logic         i_con_MtLo;
  logic [W-1:0] i_data_Mt;
  logic [W-1:0] o_data_Hi;
  logic [W-1:0] o_data_Lo;
  logic         o_con_Busy;
  logic         o_con_Done;
`ifdef MULDIV_DIVZERO_FLAG_EN
  logic         o_con_DivZero;
`endif

  modport master (
    output i_con_Start, i_con_Op,
    output i_data_A, i_data_B,
    output i_con_MtHi, i_con_MtLo, i_data_Mt,
`ifdef MULDIV_DIVZERO_FLAG_EN
    input  o_con_DivZero,
`endif
    input  o_data_Hi, o_data_Lo,
    input  o_con_Busy, o_con_Done
  );

  modport slave (
    input  i_con_Start, i_con_Op,
    input  i_data_A, i_data_B,
    input  i_con_MtHi, i_con_MtLo, i_data_Mt,
`ifdef MULDIV_DIVZERO_FLAG_EN
    output o_con_DivZero,
`endif
    output o_data_Hi, o_data_Lo,
    output o_con_Busy, o_con_Done
  );

endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply or restoring
// shift-subtract divide iteration, purely combinational.
module muldiv_step #(
  parameter int W = 32
) (
  input  logic         i_div,
  input  logic [W-1:0] i_hi,
  input  logic [W-1:0] i_lo,
  input  logic [W-1:0] i_opnd,
  output logic [W-1:0] o_hi,
  output logic [W-1:0] o_lo
);

  logic [W:0] sum;
  logic [W:0] shf;
  logic [W:0] diff;

  always_comb begin
    sum  = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_opnd} : '0);
    shf  = {i_hi, i_lo[W-1]};
    diff = shf - {1'b0, i_opnd};
    o_hi = sum[W:1];
    o_lo = {sum[0], i_lo[W-1:1]};
    // remainder < divisor keeps diff[W] a clean borrow flag
    if (i_div) begin
      o_hi = diff[W] ? shf[W-1:0] : diff[W-1:0];
      o_lo = {i_lo[W-2:0], ~diff[W]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative HI/LO sequencer for mult/multu/div/divu/mthi/mtlo.
// MULDIV_DIVZERO_FLAG_EN adds a sticky o_con_DivZero flag.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int P_WIDTH = P_WIDTH_DEF
) (
  input logic     i_clk,
  input logic     i_rst,
  muldiv_if.slave bus
);

  localparam int W  = P_WIDTH;
  localparam int CW = $clog2(W) + 1;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [W-1:0]   wh_q, wh_d, wl_q, wl_d;
  logic [W-1:0]   opnd_q, opnd_d, a_q, a_d;
  logic           div_q, div_d, dz_q, dz_d;
  logic           negq_q, negq_d, negr_q, negr_d;
  logic           done_q, done_d;
  logic [W-1:0]   step_hi, step_lo;
  logic           sa, sb;
  logic [W-1:0]   mag_a, mag_b;
  logic [2*W-1:0] prod;
`ifdef MULDIV_DIVZERO_FLAG_EN
  logic           dzf_q, dzf_d;
`endif

  muldiv_step #(.W(W)) u_step (
    .i_div  (div_q),
    .i_hi   (wh_q),
    .i_lo   (wl_q),
    .i_opnd (opnd_q),
    .o_hi   (step_hi),
    .o_lo   (step_lo)
  );

  always_comb begin
    sa      = ~bus.i_con_Op[0] & bus.i_data_A[W-1];
    sb      = ~bus.i_con_Op[0] & bus.i_data_B[W-1];
    mag_a   = sa ? -bus.i_data_A : bus.i_data_A;
    mag_b   = sb ? -bus.i_data_B : bus.i_data_B;
    prod    = negq_q ? -{wh_q, wl_q} : {wh_q, wl_q};
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    wh_d    = wh_q;
    wl_d    = wl_q;
    opnd_d  = opnd_q;
    a_d     = a_q;
    div_d   = div_q;
    dz_d    = dz_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    done_d  = 1'b0;
`ifdef MULDIV_DIVZERO_FLAG_EN
    dzf_d   = dzf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.i_con_Start) begin
          state_d = RUN;
          cnt_d   = '0;
          div_d   = bus.i_con_Op[1];
          dz_d    = bus.i_con_Op[1] & (bus.i_data_B == '0);
          a_d     = bus.i_data_A;
          negq_d  = sa ^ sb;
          negr_d  = sa;
          wh_d    = '0;
          wl_d    = bus.i_con_Op[1] ? mag_a : mag_b;
          opnd_d  = bus.i_con_Op[1] ? mag_b : mag_a;
`ifdef MULDIV_DIVZERO_FLAG_EN
          dzf_d   = 1'b0;
`endif
        end else begin
          if (bus.i_con_MtHi) hi_d = bus.i_data_Mt;
          if (bus.i_con_MtLo) lo_d = bus.i_data_Mt;
        end
      end
      RUN: begin
        wh_d  = step_hi;
        wl_d  = step_lo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) state_d = FIXUP;
      end
      FIXUP: begin
        state_d = IDLE;
        done_d  = 1'b1;
`ifdef MULDIV_DIVZERO_FLAG_EN
        dzf_d   = dz_q;
`endif
        // divide by zero reports the raw dividend, no sign fixup
        if (dz_q) begin
          hi_d = a_q;
          lo_d = {W{1'b1}};
        end else if (div_q) begin
          lo_d = negq_q ? -wl_q : wl_q;
          hi_d = negr_q ? -wh_q : wh_q;
        end else begin
          {hi_d, lo_d} = prod;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      wh_q    <= '0;
      wl_q    <= '0;
      opnd_q  <= '0;
      a_q     <= '0;
      div_q   <= 1'b0;
      dz_q    <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MULDIV_DIVZERO_FLAG_EN
      dzf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      wh_q    <= wh_d;
      wl_q    <= wl_d;
      opnd_q  <= opnd_d;
      a_q     <= a_d;
      div_q   <= div_d;
      dz_q    <= dz_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      done_q  <= done_d;
`ifdef MULDIV_DIVZERO_FLAG_EN
      dzf_q   <= dzf_d;
`endif
    end
  end

  assign bus.o_data_Hi  = hi_q;
  assign bus.o_data_Lo  = lo_q;
  assign bus.o_con_Busy = (state_q != IDLE);
  assign bus.o_con_Done = done_q;
`ifdef MULDIV_DIVZERO_FLAG_EN
  assign bus.o_con_DivZero = dzf_q;
`endif

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Iterative sequencer for the MIPS HI/LO instructions: mult, multu, div, divu, mthi and mtlo.
- Runs one shift-add (multiply) or restoring shift-subtract (divide) step per clock over P_WIDTH cycles, then applies a sign-fixup step and commits the result to HI/LO.
- Sits beside the single-cycle ALU in the execute stage. Control stalls the pipeline while o_con_Busy is high.

Parameters:
- P_WIDTH, 32, operand width. Also the number of RUN iterations.

Ports:
- i_clk  input  1  clock, rising edge
- i_rst  input  1  synchronous, active-high reset
- i_con_Start  input  1  start an operation; sampled only in IDLE
- i_con_Op  input  2  0=mult, 1=multu, 2=div, 3=divu
- i_data_A  input  P_WIDTH  rs operand (multiplicand or dividend)
- i_data_B  input  P_WIDTH  rt operand (multiplier or divisor)
- i_con_MtHi  input  1  write i_data_Mt to HI
- i_con_MtLo  input  1  write i_data_Mt to LO
- i_data_Mt  input  P_WIDTH  mthi/mtlo data
- o_data_Hi  output  P_WIDTH  HI register
- o_data_Lo  output  P_WIDTH  LO register
- o_con_Busy  output  1  operation in progress
- o_con_Done  output  1  one-cycle pulse when the result is committed

Behaviour:
- Clock and reset: one clock (i_clk); reset is synchronous and active-high (i_rst).
- Reset values: o_data_Hi=0, o_data_Lo=0, o_con_Busy=0, o_con_Done=0, state=IDLE, iteration counter=0. Reset mid-operation aborts it, and HI/LO read 0 on the following cycle.
- FSM states and transitions:
  - IDLE: Start -> RUN. Operands are latched; for signed ops they are converted to magnitudes and the result signs recorded (quotient sign = signA^signB, product sign = signA^signB, remainder sign = signA).
  - RUN: one iteration per cycle; after P_WIDTH iterations -> FIXUP.
  - FIXUP: sign correction applied, HI/LO written -> IDLE, o_con_Done=1 on the next cycle.
- Timing, with the Start cycle as cycle 0:
  - o_con_Busy=1 in cycles 1..P_WIDTH+1.
  - o_con_Done=1 and new HI/LO visible in cycle P_WIDTH+2 (34 for P_WIDTH=32).
  - Busy=0 in that cycle, and a new Start is accepted in it.
- o_con_Busy is high exactly when state != IDLE.
- HI/LO hold their old values during RUN and FIXUP. Working registers are separate.
- Multiply: {HI,LO} = full 2*P_WIDTH-bit product. Signed product is two's-complement negated in FIXUP if the product sign is set.
- Divide: LO = quotient, HI = remainder. Signed results are negated per the recorded signs.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0, with no trap.
- Divide by zero: runs full latency, then LO=all ones and HI=i_data_A (unmodified dividend), with no sign fixup.
- Start while Busy is ignored; the operation is not queued.
- MtHi/MtLo:
  - Written at the clock edge when in IDLE and Start=0.
  - Ignored while Busy.
  - If Start and Mt coincide in IDLE, Start wins and Mt is dropped.
  - MtHi and MtLo together write both registers.
- i_con_Op and operands are sampled only at the Start edge. Later changes have no effect.

Optional Feature:
- Macro: MULDIV_DIVZERO_FLAG_EN.
- Defined: adds output port o_con_DivZero (1 bit).
  - Set on the Done cycle of a div/divu with B==0.
  - Stays high until the next accepted Start or reset; reset value 0.
- Undefined: port absent, no flag logic. Divide-by-zero results are unchanged.

Decomposition:
- muldiv_pkg:
  - Op encoding constants OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - State enum (IDLE, RUN, FIXUP).
  - Default width constant 32.
- Sub-module muldiv_step: combinational single-iteration datapath.
  - Multiply: conditional add plus shift.
  - Divide: trial subtract, restore, quotient bit.
  - Controller owns the FSM, counter, sign handling and HI/LO.

Test Plan:
- multu A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; Busy cycles 1..33, Done in cycle 34 only.
- mult A=0xFFFFFFFD (-3), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; then divu 100/7 -> LO=14, HI=2.
- div A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- divu 5/0 -> LO=0xFFFFFFFF, HI=5; with MULDIV_DIVZERO_FLAG_EN, o_con_DivZero=1 from cycle 34 until the next Start.
- mthi 0x1234 in IDLE -> HI=0x1234 next cycle; MtLo and a second Start during Busy -> ignored, first result intact; Start+MtHi together in IDLE -> Start taken.
- i_rst pulsed in cycle 10 of a mult -> cycle 11: Busy=0, HI=LO=0, Done never pulses; a Start in cycle 11 runs normally.
